// File: rtl/color_overlay_render_if.sv
// Pixel-stream bundle between the binarisation stage, the overlay renderer and
// the output formatter.
interface color_overlay_render_if;
    logic        pix_valid_in;
    logic [23:0] rgb_in;
    logic        Binary_in;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic [2:0]  mode;

    logic [23:0] rgb_render;
    logic        pix_valid_out;
    logic [11:0] bbox_x_min;
    logic [11:0] bbox_x_max;
    logic [10:0] bbox_y_min;
    logic [10:0] bbox_y_max;
    logic        bbox_valid;
    logic        frame_done;

    modport slave (
        input  pix_valid_in, rgb_in, Binary_in, h_cnt, v_cnt, mode,
        output rgb_render, pix_valid_out, bbox_x_min, bbox_x_max,
               bbox_y_min, bbox_y_max, bbox_valid, frame_done
    );

    modport master (
        output pix_valid_in, rgb_in, Binary_in, h_cnt, v_cnt, mode,
        input  rgb_render, pix_valid_out, bbox_x_min, bbox_x_max,
               bbox_y_min, bbox_y_max, bbox_valid, frame_done
    );
endinterface

// File: rtl/color_overlay_render.sv
// Two-stage pixel renderer: detection mask, centre target box and an outline of
// the previous frame's detection bounding box.
module color_overlay_render #(
    parameter int          IMG_WIDTH   = 320,
    parameter int          IMG_HEIGHT  = 240,
    parameter int          CROSS_HALF  = 16,
    parameter int          MIN_PIXELS  = 64,
    parameter logic [23:0] MASK_COLOR  = 24'h00FF00,
    parameter logic [23:0] CROSS_COLOR = 24'hFFFF00,
    parameter logic [23:0] BOX_COLOR   = 24'hFF0000
) (
    input  logic                   pclk,
    input  logic                   rst,
    color_overlay_render_if.slave  vid
);

    localparam logic [11:0] X_END   = 12'(IMG_WIDTH);
    localparam logic [10:0] Y_END   = 11'(IMG_HEIGHT);
    localparam logic [11:0] X_LAST  = 12'(IMG_WIDTH - 1);
    localparam logic [10:0] Y_LAST  = 11'(IMG_HEIGHT - 1);
    localparam logic [11:0] CX_LO   = 12'(IMG_WIDTH / 2 - CROSS_HALF);
    localparam logic [11:0] CX_HI   = 12'(IMG_WIDTH / 2 + CROSS_HALF);
    localparam logic [10:0] CY_LO   = 11'(IMG_HEIGHT / 2 - CROSS_HALF);
    localparam logic [10:0] CY_HI   = 11'(IMG_HEIGHT / 2 + CROSS_HALF);
    localparam logic [19:0] CNT_MAX = '1;
    localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

    logic [11:0] acc_x_min_q, acc_x_max_q;
    logic [10:0] acc_y_min_q, acc_y_max_q;
    logic [19:0] acc_cnt_q;
    logic [11:0] upd_x_min, upd_x_max;
    logic [10:0] upd_y_min, upd_y_max;
    logic [19:0] upd_cnt;
    logic        active, det, eof;

    logic [11:0] bbox_x_min_q, bbox_x_max_q;
    logic [10:0] bbox_y_min_q, bbox_y_max_q;
    logic        bbox_valid_q, frame_done_q;

    logic [23:0] base_q;
    logic [11:0] h1_q;
    logic [10:0] v1_q;
    logic [2:1]  mode1_q;
    logic        valid1_q;

    logic        on_cross, on_box;
    logic [23:0] rgb_render_d, rgb_render_q;
    logic        pix_valid_out_q;

    // Accumulator values including the current pixel, so the end-of-frame
    // pixel's own detection lands in the latched box.
    always_comb begin
        active    = vid.pix_valid_in && (vid.h_cnt < X_END) && (vid.v_cnt < Y_END);
        det       = active && vid.Binary_in;
        eof       = active && (vid.h_cnt == X_LAST) && (vid.v_cnt == Y_LAST);
        upd_x_min = acc_x_min_q;
        upd_x_max = acc_x_max_q;
        upd_y_min = acc_y_min_q;
        upd_y_max = acc_y_max_q;
        upd_cnt   = acc_cnt_q;
        if (det) begin
            if (vid.h_cnt < acc_x_min_q) upd_x_min = vid.h_cnt;
            if (vid.h_cnt > acc_x_max_q) upd_x_max = vid.h_cnt;
            if (vid.v_cnt < acc_y_min_q) upd_y_min = vid.v_cnt;
            if (vid.v_cnt > acc_y_max_q) upd_y_max = vid.v_cnt;
            if (acc_cnt_q != CNT_MAX) upd_cnt = acc_cnt_q + 20'd1;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            acc_x_min_q  <= X_LAST;
            acc_x_max_q  <= '0;
            acc_y_min_q  <= Y_LAST;
            acc_y_max_q  <= '0;
            acc_cnt_q    <= '0;
            bbox_x_min_q <= '0;
            bbox_x_max_q <= '0;
            bbox_y_min_q <= '0;
            bbox_y_max_q <= '0;
            bbox_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= eof;
            if (eof) begin
                bbox_x_min_q <= upd_x_min;
                bbox_x_max_q <= upd_x_max;
                bbox_y_min_q <= upd_y_min;
                bbox_y_max_q <= upd_y_max;
                bbox_valid_q <= (upd_cnt >= MIN_CNT);
                acc_x_min_q  <= X_LAST;
                acc_x_max_q  <= '0;
                acc_y_min_q  <= Y_LAST;
                acc_y_max_q  <= '0;
                acc_cnt_q    <= '0;
            end else begin
                acc_x_min_q  <= upd_x_min;
                acc_x_max_q  <= upd_x_max;
                acc_y_min_q  <= upd_y_min;
                acc_y_max_q  <= upd_y_max;
                acc_cnt_q    <= upd_cnt;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            h1_q     <= '0;
            v1_q     <= '0;
            mode1_q  <= '0;
            valid1_q <= 1'b0;
        end else begin
            base_q   <= (vid.mode[0] && vid.Binary_in) ? MASK_COLOR : vid.rgb_in;
            h1_q     <= vid.h_cnt;
            v1_q     <= vid.v_cnt;
            mode1_q  <= vid.mode[2:1];
            valid1_q <= vid.pix_valid_in;
        end
    end

    // Box outline uses the latched registers as they stand now, i.e. the
    // previous frame's result.
    always_comb begin
        on_cross = (((h1_q == CX_LO) || (h1_q == CX_HI)) && (v1_q >= CY_LO) && (v1_q <= CY_HI)) ||
                   (((v1_q == CY_LO) || (v1_q == CY_HI)) && (h1_q >= CX_LO) && (h1_q <= CX_HI));
        on_box   = (((h1_q == bbox_x_min_q) || (h1_q == bbox_x_max_q)) &&
                    (v1_q >= bbox_y_min_q) && (v1_q <= bbox_y_max_q)) ||
                   (((v1_q == bbox_y_min_q) || (v1_q == bbox_y_max_q)) &&
                    (h1_q >= bbox_x_min_q) && (h1_q <= bbox_x_max_q));
        rgb_render_d = base_q;
        if (mode1_q[1] && on_cross)
            rgb_render_d = CROSS_COLOR;
        else if (mode1_q[2] && bbox_valid_q && on_box)
            rgb_render_d = BOX_COLOR;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rgb_render_q    <= '0;
            pix_valid_out_q <= 1'b0;
        end else begin
            rgb_render_q    <= rgb_render_d;
            pix_valid_out_q <= valid1_q;
        end
    end

    assign vid.rgb_render    = rgb_render_q;
    assign vid.pix_valid_out = pix_valid_out_q;
    assign vid.bbox_x_min    = bbox_x_min_q;
    assign vid.bbox_x_max    = bbox_x_max_q;
    assign vid.bbox_y_min    = bbox_y_min_q;
    assign vid.bbox_y_max    = bbox_y_max_q;
    assign vid.bbox_valid    = bbox_valid_q;
    assign vid.frame_done    = frame_done_q;

endmodule

// File: doc/color_overlay_render.md
# color_overlay_render

Pipelined pixel renderer for the colour-detection video path: masks detected pixels in a configurable colour and draws a configurable centre target box. It also accumulates a per-frame bounding box of detected pixels and outlines the previous frame's box on the live video. It sits between the binarisation stage and the video output formatter, on the pixel clock.

## Interface
- IMG_WIDTH, 320, active pixels per line
- IMG_HEIGHT, 240, active lines per frame
- CROSS_HALF, 16, half-size of centre target box in pixels
- MIN_PIXELS, 64, minimum detected pixels per frame for a valid bounding box
- MASK_COLOR, 24'h00FF00, fill colour for detected pixels
- CROSS_COLOR, 24'hFFFF00, centre target box colour
- BOX_COLOR, 24'hFF0000, bounding-box outline colour
- pclk  input  1  pixel clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- pix_valid_in  input  1  pixel qualifier for rgb_in/Binary_in/h_cnt/v_cnt
- rgb_in  input  24  pixel {R[23:16],G[15:8],B[7:0]}
- Binary_in  input  1  1 = pixel matches target colour
- h_cnt  input  12  pixel column, 0..IMG_WIDTH-1 active
- v_cnt  input  11  pixel row, 0..IMG_HEIGHT-1 active
- mode  input  3  [0] mask enable, [1] centre box enable, [2] bbox overlay enable; sampled per pixel
- rgb_render  output  24  rendered pixel
- pix_valid_out  output  1  qualifier for rgb_render
- bbox_x_min, bbox_x_max  output  12  latched box columns
- bbox_y_min, bbox_y_max  output  11  latched box rows
- bbox_valid  output  1  latched box holds ≥ MIN_PIXELS detections
- frame_done  output  1  one-cycle pulse when the box is latched

## Operation
- Active pixel: pix_valid_in=1 and h_cnt<IMG_WIDTH and v_cnt<IMG_HEIGHT.
- Accumulators (acc_x_min/max, acc_y_min/max, acc_cnt):
  - Updated only on an active pixel with Binary_in=1.
  - Min/max updated by compare.
  - acc_cnt is 20 bits, saturating at 2^20-1.
- End of frame: the active pixel at (IMG_WIDTH-1, IMG_HEIGHT-1).
  - That pixel's own detection is included in the result.
  - Latch registers: bbox_* get the updated accumulator values; bbox_valid = (count ≥ MIN_PIXELS).
  - If bbox_valid=0, the bbox_* coordinates still latch but are not drawn.
  - frame_done pulses for 1 cycle.
  - Accumulators return to init values on the same edge: min = IMG_WIDTH-1 / IMG_HEIGHT-1, max = 0, cnt = 0.
- Stage 1 (registered): base = MASK_COLOR if mode[0] and Binary_in, else rgb_in.
  - Stage 1 also registers h_cnt, v_cnt, mode and valid.
- Stage 2 (registered), priority order:
  1. CROSS_COLOR if mode[1] and the pixel is on the centre box. Centre box: h = IMG_WIDTH/2±CROSS_HALF with v inside [IMG_HEIGHT/2-CROSS_HALF, IMG_HEIGHT/2+CROSS_HALF], or v = IMG_HEIGHT/2±CROSS_HALF with h inside the same-size h range.
  2. BOX_COLOR if mode[2] and bbox_valid and the pixel is on the latched box outline. Outline: h equals x_min or x_max with v in [y_min, y_max], or v equals y_min or y_max with h in [x_min, x_max].
  3. Otherwise base.
- Stage 2 compares against the latched bbox registers as they stand when the pixel is in stage 2. The current frame is therefore drawn with the previous frame's box.
- Inactive or invalid pixels still flow through the pipeline. Overlay rules apply by coordinate. pix_valid_out follows the input valid.
- A frame that ends with no end-of-frame pixel (truncated) keeps accumulating into the next frame. No timeout.

## Timing
- Latency is exactly 2 pclk from the input sample to rgb_render/pix_valid_out. Throughput is 1 pixel/cycle. No backpressure.
- bbox_*, bbox_valid and frame_done update on the edge that samples the end-of-frame pixel, i.e. 1 cycle after input.
- Reset, asynchronous, takes effect immediately mid-frame:
  - rgb_render=0, pix_valid_out=0, bbox_* = 0, bbox_valid=0, frame_done=0.
  - Pipeline registers are 0; accumulators go to init values.
  - The first complete frame after reset release produces the first valid box.
- A mode change takes effect for the pixel sampled on that cycle, with output 2 cycles later. No frame-boundary synchronisation.

## Test plan
- Passthrough: mode=0, Binary_in=1, rgb_in=24'h123456 at (0,0) -> rgb_render=24'h123456 with pix_valid_out=1 exactly 2 cycles later.
- Mask and centre priority:
  - mode=3'b011, Binary_in=1 at (144,120) -> 24'hFFFF00 (centre box wins over mask).
  - Same inputs at (10,10) -> 24'h00FF00.
- Bounding box: frame 1 has Binary_in=1 on the 100 pixels of the rectangle x 50..59, y 30..39.
  - At (319,239): frame_done pulse; bbox = (50,59,30,39); bbox_valid=1.
  - Frame 2 with mode=3'b100: pixel (50,35) -> 24'hFF0000; (55,35) -> rgb_in.
- Threshold: frame with 63 detections -> bbox_valid=0 and no outline drawn. Frame with exactly 64 detections -> bbox_valid=1.
- Last-pixel detection: single Binary_in=1 at (319,239) with MIN_PIXELS=1 -> bbox = (319,319,239,239), bbox_valid=1.
- Mid-frame reset: assert rst at pixel (100,100) of a frame with detections.
  - Outputs read 0 immediately.
  - The next full frame yields a box built only from post-reset detections.
  - Invalid pixels (pix_valid_in=0, Binary_in=1) never affect the box.
